mux_scan_sel: RTL and testbench

- Parametrised N-channel registered multiplexer, the successor to the team's fixed 8:1 and 16:1 muxes.
- Supports generic channel count and data width.
- Two modes:
  - Manual mode: select is taken from the s port.
  - Auto-scan mode: an internal sequencer steps through mask-enabled channels, holding each for a programmable dwell time.
- Sits between multi-channel sensor/data sources and a single downstream consumer. Gives a coherent registered (y, ch) pair plus a valid strobe and a scan-wrap pulse.

---
 rtl/mux_scan_sel_if.sv | 20 ++
 rtl/mux_scan_sel.sv | 74 +++++++
 tb/tb_mux_scan_sel.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mux_scan_sel_if.sv
// mux_scan_sel_if: channel data, scan controls and registered outputs of mux_scan_sel
interface mux_scan_sel_if #(
  parameter int N_CH    = 16,
  parameter int W       = 1,
  parameter int DWELL_W = 8
);
  localparam int SW = $clog2(N_CH);
  logic [N_CH*W-1:0]  d;
  logic               e_n;
  logic               mode;
  logic [SW-1:0]      s;
  logic [DWELL_W-1:0] dwell;
  logic [N_CH-1:0]    mask;
  logic [W-1:0]       y;
  logic [SW-1:0]      ch;
  logic               y_valid;
  logic               wrap;
  modport master (output d, e_n, mode, s, dwell, mask, input y, ch, y_valid, wrap);
  modport slave  (input d, e_n, mode, s, dwell, mask, output y, ch, y_valid, wrap);
endinterface

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: N-channel registered mux with manual select and masked auto-scan sequencer
module mux_scan_sel #(
  parameter int N_CH    = 16,
  parameter int W       = 1,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_sel_if.slave bus
);
  localparam int SW = $clog2(N_CH);
  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;
  state_t             state_q, state_d;
  logic [SW-1:0]      ch_q, ch_d, lo, nx;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]       y_q, y_d;
  logic               y_valid_q, wrap_q, wrap_d, ok, hit;
  logic [W-1:0]       dv [N_CH];
  always_comb begin
    lo = '0;
    nx = '0;
    hit = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (bus.mask[k]) lo = SW'(k);
      if (bus.mask[k] && k > int'(ch_q)) begin
        nx = SW'(k);
        hit = 1'b1;
      end
    end
    for (int k = 0; k < N_CH; k++) dv[k] = bus.d[k*W +: W];
    // an all-zero mask parks the sequencer in IDLE so resumption restarts like a fresh entry
    state_d = bus.e_n ? IDLE : !bus.mode ? MANUAL : |bus.mask ? SCAN : IDLE;
    ch_d = ch_q;
    cnt_d = '0;
    ok = 1'b0;
    wrap_d = 1'b0;
    if (state_d == MANUAL) begin
      ch_d = bus.s;
      ok = int'(bus.s) < N_CH;
    end else if (state_d == SCAN) begin
      ok = 1'b1;
      if (state_q != SCAN) ch_d = lo;
      else if (!bus.mask[ch_q] && y_valid_q) begin
        ok = 1'b0;
        cnt_d = cnt_q;
      end else if (!bus.mask[ch_q] || cnt_q >= bus.dwell) begin
        ch_d = hit ? nx : lo;
        wrap_d = !hit;
      end else cnt_d = cnt_q + DWELL_W'(1);
    end
    y_d = ok ? dv[ch_d] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= ok;
      wrap_q    <= wrap_d;
    end
  end
  assign bus.y       = y_q;
  assign bus.ch      = ch_q;
  assign bus.y_valid = y_valid_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_mux_scan_sel.sv
// tb_mux_scan_sel: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_mux_scan_sel;
  typedef struct {logic y; logic [3:0] ch; logic v; logic w;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t q2[$];
  mux_scan_sel_if #(.N_CH(16), .W(1), .DWELL_W(8)) bus ();
  mux_scan_sel_if #(.N_CH(12), .W(1), .DWELL_W(8)) b2 ();
  mux_scan_sel #(.N_CH(16), .W(1), .DWELL_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mux_scan_sel #(.N_CH(12), .W(1), .DWELL_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  always #5 clk = ~clk;
  task automatic cmp(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [3:0] c, input logic v, input logic w);
    exp_t e;
    e.y = v ? bus.d[c] : 1'b0;
    e.ch = c;
    e.v = v;
    e.w = w;
    q.push_back(e);
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp($sformatf("y@%0t", $time), int'(bus.y), int'(e.y));
      cmp($sformatf("ch@%0t", $time), int'(bus.ch), int'(e.ch));
      cmp($sformatf("y_valid@%0t", $time), int'(bus.y_valid), int'(e.v));
      cmp($sformatf("wrap@%0t", $time), int'(bus.wrap), int'(e.w));
    end
    if (q2.size() != 0) begin
      e = q2.pop_front();
      cmp($sformatf("n12_y@%0t", $time), int'(b2.y), int'(e.y));
      cmp($sformatf("n12_ch@%0t", $time), int'(b2.ch), int'(e.ch));
      cmp($sformatf("n12_y_valid@%0t", $time), int'(b2.y_valid), int'(e.v));
    end
  end
  initial begin
    logic [3:0] seq_a [13] = '{0, 0, 0, 3, 3, 3, 8, 8, 8, 0, 0, 0, 3};
    logic [3:0] seq_b [7]  = '{0, 0, 3, 3, 3, 8, 8};
    logic [11:0] d2 = 12'hA5C;
    exp_t e2;
    bus.d = 16'hA5C3; bus.e_n = 1'b1; bus.mode = 1'b0; bus.s = '0; bus.dwell = '0; bus.mask = '0;
    b2.d = d2; b2.e_n = 1'b0; b2.mode = 1'b0; b2.s = '0; b2.dwell = '0; b2.mask = '0;
    repeat (2) @(negedge clk);
    cmp("reset_y", int'(bus.y), 0);
    cmp("reset_ch", int'(bus.ch), 0);
    cmp("reset_y_valid", int'(bus.y_valid), 0);
    cmp("reset_wrap", int'(bus.wrap), 0);
    rst_n = 1'b1;
    bus.e_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.s = 4'(k);
      b2.s = 4'(k);
      e2.y = (k < 12) ? d2[k] : 1'b0;
      e2.ch = 4'(k);
      e2.v = k < 12;
      e2.w = 1'b0;
      q2.push_back(e2);
      push(4'(k), 1'b1, 1'b0);
    end
    cmp("pre_reset_y", int'(bus.y), 1);
    rst_n = 1'b0;
    #1;
    cmp("async_reset_y", int'(bus.y), 0);
    cmp("async_reset_ch", int'(bus.ch), 0);
    cmp("async_reset_y_valid", int'(bus.y_valid), 0);
    push(4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.e_n = 1'b1;
    repeat (5) push(4'd0, 1'b0, 1'b0);
    bus.e_n = 1'b0; bus.mode = 1'b1; bus.mask = 16'h0109; bus.dwell = 8'd2;
    for (int i = 0; i < 13; i++) push(seq_a[i], 1'b1, i == 9);
    bus.mask = 16'h0101;
    push(4'd3, 1'b0, 1'b0);
    push(4'd8, 1'b1, 1'b0);
    bus.mask = 16'h0000;
    repeat (2) push(4'd8, 1'b0, 1'b0);
    bus.mask = 16'h0001;
    push(4'd0, 1'b1, 1'b0);
    bus.mask = 16'h0109;
    for (int i = 0; i < 7; i++) push(seq_b[i], 1'b1, 1'b0);
    bus.mode = 1'b0; bus.s = 4'd5;
    push(4'd5, 1'b1, 1'b0);
    bus.mode = 1'b1;
    repeat (3) push(4'd0, 1'b1, 1'b0);
    push(4'd3, 1'b1, 1'b0);
    bus.mask = 16'h0040; bus.dwell = 8'd0;
    push(4'd3, 1'b0, 1'b0);
    push(4'd6, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      bus.d = k[0] ? 16'hFFBF : 16'h0040;
      push(4'd6, 1'b1, 1'b1);
    end
    bus.d = 16'hA5C3;
    bus.e_n = 1'b1;
    push(4'd6, 1'b0, 1'b0);
    bus.e_n = 1'b0; bus.mask = 16'h0109; bus.dwell = 8'd1;
    repeat (2) push(4'd0, 1'b1, 1'b0);
    push(4'd3, 1'b1, 1'b0);
    bus.dwell = 8'd3;
    repeat (3) push(4'd3, 1'b1, 1'b0);
    bus.dwell = 8'd1;
    push(4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 10 && (q.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    if (q.size() != 0 || q2.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size() + q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
